// File: rtl/generic_banked_double_port_sram.sv
// generic_banked_double_port_sram
//   Behavioural dual-port SRAM (one write port, one read port) built from NUM_BANKS
//   address-interleaved banks. It has configurable read latency (1 or 2), a read-valid pulse,
//   write-first forwarding on same-address read/write collisions and a saturating 16-bit
//   collision counter.
//
//   Optional feature macro: GENERIC_BANKED_SRAM_ZERO_INIT_EN
//     When defined, a reset starts a clear sequence that zeroes every row (all banks in
//     parallel, one row per cycle) while BUSY is high. When undefined, BUSY is tied low and the
//     contents are undefined until written.
//
// Ports
//   CLK         clock, rising edge
//   RST         synchronous reset, active high
//   REB / WEB   read / write enable, active high
//   AA / AB     write / read address
//   D / M       write data / per-bit write mask (1 = overwrite)
//   Q / QV      read data / one-cycle read-valid pulse
//   BUSY        zero-initialisation in progress; accesses are ignored
//   COLLISIONS  saturating count of accepted same-address read+write cycles

`timescale 1ns / 1ps

module generic_banked_double_port_sram #(
   parameter int unsigned  WIDTH         = 128,
   parameter int unsigned  NUM_ROWS      = 4096,
   parameter int unsigned  NUM_BANKS     = 4,
   parameter int unsigned  READ_LATENCY  = 1,
   localparam int unsigned ADDRESS_WIDTH = $clog2(NUM_ROWS)
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     REB,
   input  logic                     WEB,
   input  logic [ADDRESS_WIDTH-1:0] AA,
   input  logic [ADDRESS_WIDTH-1:0] AB,
   input  logic [WIDTH-1:0]         D,
   input  logic [WIDTH-1:0]         M,
   output logic [WIDTH-1:0]         Q,
   output logic                     QV,
   output logic                     BUSY,
   output logic [15:0]              COLLISIONS
);

   localparam int unsigned RowsPerBank = NUM_ROWS / NUM_BANKS;
   localparam int unsigned BankBits    = $clog2(NUM_BANKS);
   localparam int unsigned BankW       = (BankBits > 0) ? BankBits : 1;
   localparam int unsigned RowW        = (ADDRESS_WIDTH > BankBits) ?
                                         (ADDRESS_WIDTH - BankBits) : 1;

   // ---------------------------------------------------------------------------------------
   // Address decode: low bits select the bank, the remaining bits select the row.
   // ---------------------------------------------------------------------------------------
   logic [ADDRESS_WIDTH-1:0] wa_shift, rb_shift;
   logic [BankW-1:0]         wa_bank, rb_bank;
   logic [RowW-1:0]          wa_row, rb_row;
   logic                     wa_in_range, rb_in_range;
   logic                     same_addr;

   assign wa_shift    = AA >> BankBits;
   assign rb_shift    = AB >> BankBits;
   assign wa_row      = wa_shift[RowW-1:0];
   assign rb_row      = rb_shift[RowW-1:0];
   assign wa_bank     = BankW'(AA & ADDRESS_WIDTH'(NUM_BANKS - 1));
   assign rb_bank     = BankW'(AB & ADDRESS_WIDTH'(NUM_BANKS - 1));
   // Only reachable when NUM_ROWS is not a power of two.
   assign wa_in_range = ({1'b0, AA} < (ADDRESS_WIDTH + 1)'(NUM_ROWS));
   assign rb_in_range = ({1'b0, AB} < (ADDRESS_WIDTH + 1)'(NUM_ROWS));
   assign same_addr   = (AA == AB);

   // ---------------------------------------------------------------------------------------
   // Accept gating
   // ---------------------------------------------------------------------------------------
   logic            busy;
   logic            clr_we;
   logic [RowW-1:0] clr_row;
   logic            accept;
   logic            wr_en;
   logic            rd_en;
   logic            collide;

   assign accept  = !RST && !busy;
   assign wr_en   = accept && WEB && wa_in_range;
   assign rd_en   = accept && REB;
   assign collide = accept && REB && WEB && same_addr;

   // ---------------------------------------------------------------------------------------
   // Optional zero-initialisation sequencer
   // ---------------------------------------------------------------------------------------
`ifdef GENERIC_BANKED_SRAM_ZERO_INIT_EN
   typedef enum logic {StIdle, StClear} clr_state_e;

   clr_state_e      state_q;
   logic [RowW-1:0] clr_row_q;
   logic            busy_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= StClear;
         clr_row_q <= '0;
         busy_q    <= 1'b1;
      end else begin
         unique case (state_q)
            StClear: begin
               if (clr_row_q == RowW'(RowsPerBank - 1)) begin
                  state_q   <= StIdle;
                  clr_row_q <= '0;
                  busy_q    <= 1'b0;
               end else begin
                  clr_row_q <= clr_row_q + 1'b1;
               end
            end
            default: begin
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy    = busy_q;
   // Rows are cleared only after reset releases; every bank clears the same row in parallel.
   assign clr_we  = (state_q == StClear) && !RST;
   assign clr_row = clr_row_q;
`else
   assign busy    = 1'b0;
   assign clr_we  = 1'b0;
   assign clr_row = '0;
`endif

   assign BUSY = busy;

   // ---------------------------------------------------------------------------------------
   // Bank storage
   // ---------------------------------------------------------------------------------------
   logic [WIDTH-1:0] bank_rdata [NUM_BANKS];

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [WIDTH-1:0] mem_q [RowsPerBank];
      logic             bank_we;

      assign bank_we = wr_en && (wa_bank == BankW'(b));

      always_ff @(posedge CLK) begin
         if (clr_we) begin
            mem_q[clr_row] <= '0;
         end else if (bank_we) begin
            mem_q[wa_row] <= (D & M) | (mem_q[wa_row] & ~M);
         end
      end

      assign bank_rdata[b] = mem_q[rb_row];
   end

   // ---------------------------------------------------------------------------------------
   // Read word selection: out-of-range reads return zero; a same-address write is merged in
   // so the read sees the post-write word.
   // ---------------------------------------------------------------------------------------
   logic [WIDTH-1:0] rd_word;

   always_comb begin
      rd_word = '0;
      if (rb_in_range) begin
         rd_word = bank_rdata[rb_bank];
         if (WEB && same_addr) begin
            rd_word = (D & M) | (rd_word & ~M);
         end
      end
   end

   // ---------------------------------------------------------------------------------------
   // Read pipeline
   // ---------------------------------------------------------------------------------------
   logic [WIDTH-1:0] s1_data_q;
   logic             s1_vld_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_data_q <= '0;
         s1_vld_q  <= 1'b0;
      end else begin
         s1_vld_q <= rd_en;
         if (rd_en) begin
            s1_data_q <= rd_word;
         end
      end
   end

   if (READ_LATENCY >= 2) begin : g_lat2
      logic [WIDTH-1:0] q_q;
      logic             qv_q;

      always_ff @(posedge CLK) begin
         if (RST) begin
            q_q  <= '0;
            qv_q <= 1'b0;
         end else begin
            qv_q <= s1_vld_q;
            if (s1_vld_q) begin
               q_q <= s1_data_q;
            end
         end
      end

      assign Q  = q_q;
      assign QV = qv_q;
   end else begin : g_lat1
      assign Q  = s1_data_q;
      assign QV = s1_vld_q;
   end

   // ---------------------------------------------------------------------------------------
   // Saturating collision counter
   // ---------------------------------------------------------------------------------------
   logic [15:0] coll_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         coll_q <= '0;
      end else if (collide && (coll_q != 16'hFFFF)) begin
         coll_q <= coll_q + 16'd1;
      end
   end

   assign COLLISIONS = coll_q;

endmodule

// File: tb/tb_generic_banked_double_port_sram.sv
// Testbench for generic_banked_double_port_sram. Two instances share one stimulus stream:
// dut0 has 16 rows / latency 1, dut1 has 12 rows / latency 2 (so addresses 12..15 are out of
// range for it). Expected read responses are queued per instance at issue time and a monitor
// pops them when QV is seen.

`timescale 1ns / 1ps

module tb_generic_banked_double_port_sram;

   localparam int unsigned W    = 16;
   localparam int unsigned AW   = 4;
   localparam int unsigned NB   = 4;
   localparam int unsigned NR0  = 16;
   localparam int unsigned NR1  = 12;
   localparam int unsigned LAT0 = 1;
   localparam int unsigned LAT1 = 2;
`ifdef GENERIC_BANKED_SRAM_ZERO_INIT_EN
   localparam bit ZeroInit = 1'b1;
`else
   localparam bit ZeroInit = 1'b0;
`endif

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          REB = 1'b0;
   logic          WEB = 1'b0;
   logic [AW-1:0] AA  = '0;
   logic [AW-1:0] AB  = '0;
   logic [W-1:0]  D   = '0;
   logic [W-1:0]  M   = '0;

   logic [W-1:0]  q0, q1;
   logic          qv0, qv1, busy0, busy1;
   logic [15:0]   coll0, coll1;

   always #5 CLK = ~CLK;

   generic_banked_double_port_sram #(
      .WIDTH       (W),
      .NUM_ROWS    (NR0),
      .NUM_BANKS   (NB),
      .READ_LATENCY(LAT0)
   ) u_dut0 (
      .CLK       (CLK),
      .RST       (RST),
      .REB       (REB),
      .WEB       (WEB),
      .AA        (AA),
      .AB        (AB),
      .D         (D),
      .M         (M),
      .Q         (q0),
      .QV        (qv0),
      .BUSY      (busy0),
      .COLLISIONS(coll0)
   );

   generic_banked_double_port_sram #(
      .WIDTH       (W),
      .NUM_ROWS    (NR1),
      .NUM_BANKS   (NB),
      .READ_LATENCY(LAT1)
   ) u_dut1 (
      .CLK       (CLK),
      .RST       (RST),
      .REB       (REB),
      .WEB       (WEB),
      .AA        (AA),
      .AB        (AB),
      .D         (D),
      .M         (M),
      .Q         (q1),
      .QV        (qv1),
      .BUSY      (busy1),
      .COLLISIONS(coll1)
   );

   // ------------------------------------------------------------------------------------------
   // Reference model state
   // ------------------------------------------------------------------------------------------
   typedef struct {
      logic [W-1:0] data;
      int           cyc;
   } exp_t;

   exp_t         exp_q [2][$];
   logic [W-1:0] mem [2][16];
   int           coll_m [2];
   int           busy_rem [2];
   int           nrows [2];
   int           lat [2];
   logic [W-1:0] last_q [2];
   bit           mon_en = 1'b0;
   int           cyc = 0;
   int           n_checks = 0;
   int           n_fail = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [W-1:0] merge(input logic [W-1:0] d, input logic [W-1:0] m,
                                          input logic [W-1:0] old);
      return (d & m) | (old & ~m);
   endfunction

   // Applies one access cycle to the model of instance k.
   task automatic model(input int k, input logic re, input logic we, input logic [AW-1:0] aa,
                        input logic [AW-1:0] ab, input logic [W-1:0] d, input logic [W-1:0] m);
      exp_t         e;
      logic [W-1:0] rd;
      if (busy_rem[k] != 0) return;
      if (re) begin
         rd = (int'(ab) < nrows[k]) ? mem[k][ab] : '0;
         if (we && (aa == ab) && (int'(ab) < nrows[k])) rd = merge(d, m, rd);
         e.data = rd;
         e.cyc  = cyc + lat[k];
         exp_q[k].push_back(e);
      end
      if (re && we && (aa == ab) && (coll_m[k] < 65535)) coll_m[k]++;
      if (we && (int'(aa) < nrows[k])) mem[k][aa] = merge(d, m, mem[k][aa]);
   endtask

   task automatic step(input logic re, input logic we, input logic [AW-1:0] aa,
                       input logic [AW-1:0] ab, input logic [W-1:0] d, input logic [W-1:0] m);
      REB = re;
      WEB = we;
      AA  = aa;
      AB  = ab;
      D   = d;
      M   = m;
      model(0, re, we, aa, ab, d, m);
      model(1, re, we, aa, ab, d, m);
      @(negedge CLK);
      for (int k = 0; k < 2; k++) if (busy_rem[k] != 0) busy_rem[k]--;
      check("busy0", 32'(busy0), 32'(busy_rem[0] != 0));
      check("busy1", 32'(busy1), 32'(busy_rem[1] != 0));
      check("collisions0", 32'(coll0), 32'(coll_m[0]));
      check("collisions1", 32'(coll1), 32'(coll_m[1]));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, '0);
   endtask

   task automatic do_reset(input int drain);
      idle(drain);
      mon_en = 1'b0;
      RST    = 1'b1;
      REB    = 1'b0;
      WEB    = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      for (int k = 0; k < 2; k++) begin
         exp_q[k].delete();
         last_q[k]   = '0;
         coll_m[k]   = 0;
         busy_rem[k] = ZeroInit ? nrows[k] / NB : 0;
         if (ZeroInit) for (int i = 0; i < 16; i++) mem[k][i] = '0;
      end
      check("rst_q0", 32'(q0), 32'(0));
      check("rst_qv0", 32'(qv0), 32'(0));
      check("rst_q1", 32'(q1), 32'(0));
      check("rst_qv1", 32'(qv1), 32'(0));
      check("rst_busy0", 32'(busy0), 32'(busy_rem[0] != 0));
      check("rst_busy1", 32'(busy1), 32'(busy_rem[1] != 0));
      check("rst_coll0", 32'(coll0), 32'(0));
      check("rst_coll1", 32'(coll1), 32'(0));
      mon_en = 1'b1;
   endtask

   // ------------------------------------------------------------------------------------------
   // Monitor
   // ------------------------------------------------------------------------------------------
   task automatic mon(input int k, input logic [W-1:0] q, input logic qv);
      exp_t e;
      if (qv) begin
         if (exp_q[k].size() == 0) begin
            check($sformatf("qv%0d_spurious", k), 32'(qv), 32'(0));
         end else begin
            e = exp_q[k].pop_front();
            check($sformatf("q%0d_data", k), 32'(q), 32'(e.data));
            check($sformatf("q%0d_latency_cycle", k), 32'(cyc), 32'(e.cyc));
            last_q[k] = e.data;
         end
      end else begin
         check($sformatf("q%0d_hold", k), 32'(q), 32'(last_q[k]));
         if ((exp_q[k].size() != 0) && (exp_q[k][0].cyc <= cyc)) begin
            check($sformatf("qv%0d_missing", k), 32'(qv), 32'(1));
            void'(exp_q[k].pop_front());
         end
      end
   endtask

   always @(negedge CLK) begin
      if (mon_en) begin
         mon(0, q0, qv0);
         mon(1, q1, qv1);
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------------------------
   initial begin
      logic          re, we;
      logic [AW-1:0] aa, ab;
      nrows[0] = NR0;
      nrows[1] = NR1;
      lat[0]   = LAT0;
      lat[1]   = LAT1;
      for (int k = 0; k < 2; k++) begin
         busy_rem[k] = 0;
         coll_m[k]   = 0;
         last_q[k]   = '0;
         for (int i = 0; i < 16; i++) mem[k][i] = '0;
      end
      @(negedge CLK);
      do_reset(0);
      // Clear period (BUSY checked every step).
      idle(6);

      // Without zero-init, give every word a known value first.
      if (!ZeroInit) begin
         for (int i = 0; i < 16; i++) step(1'b0, 1'b1, AW'(i), '0, W'($urandom), 16'hFFFF);
      end

      // Read every address back-to-back (pipelined, covers out-of-range on dut1).
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, '0, AW'(i), '0, '0);
      idle(3);

      // Masked write, read on the next cycle.
      step(1'b0, 1'b1, 4'd5, '0, 16'hFFFF, 16'h00FF);
      step(1'b1, 1'b0, '0, 4'd5, '0, '0);
      idle(3);

      // Write-first collision.
      step(1'b0, 1'b1, 4'd7, '0, 16'hAAAA, 16'hFFFF);
      step(1'b1, 1'b1, 4'd7, 4'd7, 16'h5555, 16'h0F0F);
      idle(3);

      // Four consecutive reads across the banks.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, AW'(i), '0, '0);
      idle(3);

      // Out-of-range write (dropped on dut1) then read.
      step(1'b0, 1'b1, 4'd13, '0, 16'h1234, 16'hFFFF);
      step(1'b1, 1'b0, '0, 4'd13, '0, '0);
      idle(3);

      // Random traffic with frequent same-address pairs.
      for (int i = 0; i < 400; i++) begin
         re = 1'($urandom_range(0, 1));
         we = 1'($urandom_range(0, 1));
         aa = AW'($urandom_range(0, 15));
         ab = ($urandom_range(0, 3) == 0) ? aa : AW'($urandom_range(0, 15));
         step(re, we, aa, ab, W'($urandom), W'($urandom));
      end
      idle(3);

      // Accesses during BUSY are ignored; a mid-clear reset restarts the clear.
      do_reset(3);
      for (int i = 0; i < 2; i++) step(1'b1, 1'b1, AW'(i), AW'(i), 16'hFFFF, 16'hFFFF);
      do_reset(0);
      for (int i = 0; i < 6; i++) begin
         aa = AW'($urandom_range(0, 15));
         step(1'b1, 1'b1, aa, aa, W'($urandom), 16'hFFFF);
      end
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, '0, AW'(i), '0, '0);
      idle(3);

      // Collision counter saturation.
      for (int i = 0; i < 65600; i++) begin
         aa = AW'($urandom_range(0, 15));
         step(1'b1, 1'b1, aa, aa, W'($urandom), W'($urandom));
      end
      idle(4);
      check("pending0", 32'(exp_q[0].size()), 32'(0));
      check("pending1", 32'(exp_q[1].size()), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
